// File: rtl/tank_referee_if.sv
// Signal bundle between the tank referee and the two tank controllers.
// Member names match the referee's documented port names.
interface tank_referee_if;
    logic       frame_clk;
    logic [9:0] tank0_X;
    logic [9:0] tank0_Y;
    logic [9:0] tank1_X;
    logic [9:0] tank1_Y;
    logic [9:0] bullet0_X;
    logic [9:0] bullet0_Y;
    logic [9:0] bullet1_X;
    logic [9:0] bullet1_Y;
    logic [1:0] hit0;
    logic [1:0] hit1;
    logic [1:0] bull_hit0;
    logic [1:0] bull_hit1;
    logic       can_move0;
    logic       can_move1;
    logic [3:0] score0;
    logic [3:0] score1;
    logic       round_reset;
    logic [1:0] winner;
    logic [1:0] state_o;

    modport master (
        output frame_clk, tank0_X, tank0_Y, tank1_X, tank1_Y,
               bullet0_X, bullet0_Y, bullet1_X, bullet1_Y, hit0, hit1,
        input  bull_hit0, bull_hit1, can_move0, can_move1,
               score0, score1, round_reset, winner, state_o
    );

    modport slave (
        input  frame_clk, tank0_X, tank0_Y, tank1_X, tank1_Y,
               bullet0_X, bullet0_Y, bullet1_X, bullet1_Y, hit0, hit1,
        output bull_hit0, bull_hit1, can_move0, can_move1,
               score0, score1, round_reset, winner, state_o
    );
endinterface

// File: rtl/tank_referee.sv
// Two-player tank game referee: collision detection, scoring, round hold/respawn
// and game-over arbitration, evaluated once per frame strobe.
module tank_referee #(
    parameter logic [9:0] TANK_SIZE   = 10'd32,
    parameter logic [9:0] BULLET_SIZE = 10'd8,
    parameter logic [3:0] WIN_SCORE   = 4'd5,
    parameter logic [7:0] HOLD_FRAMES = 8'd60
) (
    input  logic          Clk,
    input  logic          Reset,
    tank_referee_if.slave bus
);
    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        HOLD    = 2'd1,
        RESPAWN = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_frame_q1, r_frame_q2, r_tick;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_score0, r_score1, w_score0_nxt, w_score1_nxt;
    logic [1:0] r_bull_hit0, r_bull_hit1, w_bull_hit0_nxt, w_bull_hit1_nxt;
    logic       r_can_move0, r_can_move1, w_can_move0_nxt, w_can_move1_nxt;
    logic       r_round_reset, w_round_reset_nxt;
    logic [1:0] r_winner, w_winner_nxt;

    // Box overlap in 11 bits so right/bottom edges near 1023 never wrap.
    function automatic logic f_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                       input logic [9:0] as, input logic [9:0] bx,
                                       input logic [9:0] by, input logic [9:0] bs);
        f_overlap = (11'(ax) < 11'(bx) + 11'(bs)) && (11'(bx) < 11'(ax) + 11'(as)) &&
                    (11'(ay) < 11'(by) + 11'(bs)) && (11'(by) < 11'(ay) + 11'(as));
    endfunction

    logic w_live0, w_live1, w_h0, w_h1, w_bb, w_tt, w_win0, w_win1, w_hold_done;

    assign w_live0 = (bus.hit0 == 2'b01);
    assign w_live1 = (bus.hit1 == 2'b01);
    assign w_h0 = w_live0 && f_overlap(bus.bullet0_X, bus.bullet0_Y, BULLET_SIZE,
                                       bus.tank1_X, bus.tank1_Y, TANK_SIZE);
    assign w_h1 = w_live1 && f_overlap(bus.bullet1_X, bus.bullet1_Y, BULLET_SIZE,
                                       bus.tank0_X, bus.tank0_Y, TANK_SIZE);
    assign w_bb = w_live0 && w_live1 &&
                  f_overlap(bus.bullet0_X, bus.bullet0_Y, BULLET_SIZE,
                            bus.bullet1_X, bus.bullet1_Y, BULLET_SIZE);
    assign w_tt = f_overlap(bus.tank0_X, bus.tank0_Y, TANK_SIZE,
                            bus.tank1_X, bus.tank1_Y, TANK_SIZE);
    assign w_win0      = (r_score0 >= WIN_SCORE);
    assign w_win1      = (r_score1 >= WIN_SCORE);
    assign w_hold_done = (r_cnt == HOLD_FRAMES - 8'd1);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= PLAY;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic, advanced only on frame ticks
    always_comb begin
        w_state_nxt = r_state;
        if (r_tick) begin
            case (r_state)
                PLAY:    if (w_h0 || w_h1) w_state_nxt = HOLD;
                HOLD:    if (w_hold_done) w_state_nxt = (w_win0 || w_win1) ? OVER : RESPAWN;
                RESPAWN: w_state_nxt = PLAY;
                OVER:    w_state_nxt = OVER;
            endcase
        end
    end

    // Output/datapath next values; everything holds between ticks
    always_comb begin
        w_bull_hit0_nxt   = r_bull_hit0;
        w_bull_hit1_nxt   = r_bull_hit1;
        w_can_move0_nxt   = r_can_move0;
        w_can_move1_nxt   = r_can_move1;
        w_score0_nxt      = r_score0;
        w_score1_nxt      = r_score1;
        w_cnt_nxt         = r_cnt;
        w_winner_nxt      = r_winner;
        w_round_reset_nxt = 1'b0;
        if (r_tick) begin
            case (r_state)
                PLAY: begin
                    w_bull_hit0_nxt = (!w_live0 || w_h0 || w_bb) ? 2'b00 : 2'b01;
                    w_bull_hit1_nxt = (!w_live1 || w_h1 || w_bb) ? 2'b00 : 2'b01;
                    w_can_move0_nxt = !w_tt;
                    w_can_move1_nxt = !w_tt;
                    if (w_h0 && r_score0 != 4'd15) w_score0_nxt = r_score0 + 4'd1;
                    if (w_h1 && r_score1 != 4'd15) w_score1_nxt = r_score1 + 4'd1;
                    w_cnt_nxt = 8'd0;
                end
                HOLD: begin
                    w_bull_hit0_nxt = 2'b00;
                    w_bull_hit1_nxt = 2'b00;
                    w_can_move0_nxt = 1'b0;
                    w_can_move1_nxt = 1'b0;
                    w_cnt_nxt       = r_cnt + 8'd1;
                    if (w_state_nxt == OVER)    w_winner_nxt      = {w_win1, w_win0};
                    if (w_state_nxt == RESPAWN) w_round_reset_nxt = 1'b1;
                end
                RESPAWN: begin
                    w_bull_hit0_nxt = 2'b00;
                    w_bull_hit1_nxt = 2'b00;
                    w_can_move0_nxt = 1'b1;
                    w_can_move1_nxt = 1'b1;
                end
                OVER: begin
                    w_bull_hit0_nxt = 2'b00;
                    w_bull_hit1_nxt = 2'b00;
                    w_can_move0_nxt = 1'b0;
                    w_can_move1_nxt = 1'b0;
                end
            endcase
        end
    end

    // Frame strobe synchroniser, rising-edge tick and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q1    <= 1'b0;
            r_frame_q2    <= 1'b0;
            r_tick        <= 1'b0;
            r_cnt         <= 8'd0;
            r_score0      <= 4'd0;
            r_score1      <= 4'd0;
            r_bull_hit0   <= 2'b00;
            r_bull_hit1   <= 2'b00;
            r_can_move0   <= 1'b1;
            r_can_move1   <= 1'b1;
            r_round_reset <= 1'b0;
            r_winner      <= 2'b00;
        end else begin
            r_frame_q1    <= bus.frame_clk;
            r_frame_q2    <= r_frame_q1;
            r_tick        <= r_frame_q1 & ~r_frame_q2;
            r_cnt         <= w_cnt_nxt;
            r_score0      <= w_score0_nxt;
            r_score1      <= w_score1_nxt;
            r_bull_hit0   <= w_bull_hit0_nxt;
            r_bull_hit1   <= w_bull_hit1_nxt;
            r_can_move0   <= w_can_move0_nxt;
            r_can_move1   <= w_can_move1_nxt;
            r_round_reset <= w_round_reset_nxt;
            r_winner      <= w_winner_nxt;
        end
    end

    assign bus.bull_hit0   = r_bull_hit0;
    assign bus.bull_hit1   = r_bull_hit1;
    assign bus.can_move0   = r_can_move0;
    assign bus.can_move1   = r_can_move1;
    assign bus.score0      = r_score0;
    assign bus.score1      = r_score1;
    assign bus.round_reset = r_round_reset;
    assign bus.winner      = r_winner;
    assign bus.state_o     = r_state;
endmodule

// File: doc/tank_referee.md
TANK_REFEREE -- requirements
Module: tank_referee

Interface
REQ-001 Parameter TANK_SIZE, default 10'd32: side length of the square tank box in pixels.
REQ-002 Parameter BULLET_SIZE, default 10'd8: side length of the square bullet box in pixels.
REQ-003 Parameter WIN_SCORE, default 4'd5: score that ends the game.
REQ-004 Parameter HOLD_FRAMES, default 8'd60: number of frames play is frozen after a scoring hit.
REQ-005 Clk  in  1: 50 MHz system clock; one clock; all state updates on posedge Clk.
REQ-006 Reset  in  1: synchronous, active-high reset.
REQ-007 frame_clk  in  1: frame strobe, about 60 Hz, asynchronous-level and sampled on Clk.
REQ-008 tank0_X, tank0_Y, tank1_X, tank1_Y  in  10 each: top-left corner of each tank.
REQ-009 bullet0_X, bullet0_Y, bullet1_X, bullet1_Y  in  10 each: top-left corner of each bullet.
REQ-010 hit0, hit1  in  2 each: bullet status from each tank controller; 2'b01 = bullet in flight, any other value = no bullet.
REQ-011 bull_hit0, bull_hit1  out  2 each: bullet permission back to each tank controller; 2'b01 = keep flying, 2'b00 = cancel the bullet.
REQ-012 can_move0, can_move1  out  1 each: 1 = tank may advance; 0 = tank must back off.
REQ-013 score0, score1  out  4 each: round wins per player.
REQ-014 round_reset  out  1: one-Clk pulse that re-spawns both tanks.
REQ-015 winner  out  2: 00 = none, 01 = player 0, 10 = player 1, 11 = draw.
REQ-016 state_o  out  2: current FSM state, for debug.

Function
REQ-017 frame_clk shall be registered twice. frame_tick is a registered pulse, asserted for exactly one Clk cycle after a 0->1 transition of frame_clk.
REQ-018 All evaluation and all output updates, except round_reset, shall occur only in cycles where frame_tick=1; between ticks every output holds its value.
REQ-019 Box overlap test shall use 11-bit unsigned arithmetic, with no wrap: (ax < bx+bw) && (bx < ax+aw) && (ay < by+bh) && (by < ay+ah).
REQ-020 A bullet k is "live" when hit_k==2'b01.
REQ-021 Event H0 = live bullet 0 overlaps tank 1. Event H1 = live bullet 1 overlaps tank 0.
REQ-022 Event BB = both bullets live and the two bullet boxes overlap.
REQ-023 Event TT = the tank boxes overlap.
REQ-024 FSM states: PLAY=2'd0, HOLD=2'd1, RESPAWN=2'd2, OVER=2'd3.
REQ-025 PLAY, per tick, bullet permission:
- bull_hit_k = 2'b00 if bullet k is not live, or if Hk or BB holds;
- otherwise bull_hit_k = 2'b01.
REQ-026 PLAY, per tick, movement: can_move0 = can_move1 = ~TT.
REQ-027 PLAY, per tick, scoring: on H0, score0 increments; on H1, score1 increments; both may increment in the same tick.
REQ-028 Scores shall saturate at 4'd15. BB alone shall not change any score.
REQ-029 PLAY -> HOLD on any tick where H0 or H1 holds. The frame counter loads 0 on this transition.
REQ-030 HOLD, per tick:
- bull_hit0 = bull_hit1 = 2'b00;
- can_move0 = can_move1 = 0;
- the frame counter increments.
REQ-031 HOLD exit, evaluated on the tick where the counter reaches HOLD_FRAMES-1:
- if either score >= WIN_SCORE, go to OVER;
- otherwise go to RESPAWN.
REQ-032 RESPAWN shall assert round_reset for exactly one Clk cycle, in the cycle of entry, not tick-gated. It then goes to PLAY on the next tick.
REQ-033 Entering OVER shall latch winner:
- 01 if only score0 >= WIN_SCORE;
- 10 if only score1 >= WIN_SCORE;
- 11 if both are.
REQ-034 OVER shall be absorbing until Reset. In OVER, bull_hit = 00 and can_move = 0 for both players.
REQ-035 winner shall be 00 in every state except OVER.

Reset
REQ-036 While Reset=1 at posedge Clk, the block shall set:
- state = PLAY;
- score0 = score1 = 0;
- frame counter = 0;
- bull_hit0 = bull_hit1 = 2'b00;
- can_move0 = can_move1 = 1;
- round_reset = 0;
- winner = 00;
- the frame edge detector cleared.
REQ-037 A Reset asserted in any state, including mid-HOLD, shall override all other updates in that cycle. The first tick after Reset deasserts shall be evaluated as PLAY.

Verification
REQ-038 Scenario: tank0=(100,240), tank1=(540,240), bullet0 live at (300,250), no overlap; one tick -> bull_hit0=01, can_move=1/1, scores unchanged.
REQ-039 Scenario: bullet0 live at (536,250) overlapping tank1; one tick -> bull_hit0=00, score0=1, state HOLD. After 60 ticks -> one-cycle round_reset, then PLAY.
REQ-040 Scenario: both bullets live at (300,250) and (304,252) -> both bull_hit=00 (BB), scores unchanged, state stays PLAY.
REQ-041 Scenario: tank0=(200,200), tank1=(231,200), i.e. 1-pixel overlap -> can_move0=can_move1=0. Move tank1 to (232,200) -> both become 1 on the next tick.
REQ-042 Scenario: score0=4, score1=4; H0 and H1 in the same tick -> both scores become 5; after the HOLD period -> OVER with winner=11. Further ticks change nothing.
REQ-043 Scenario: Reset asserted mid-HOLD at frame count 30 -> next cycle: state PLAY, scores 0, can_move=1/1, round_reset=0.
